mem_client: RTL and testbench

// - Initiator side of the memory block's read and cons ports; the memory block is the responder.
// - Accepts CAR / CDR / CONS commands from the evaluator over a valid/ready command port.
// - Drives mem_req/mem_addr or cons_en/cons_car/cons_cdr, waits for the memory handshake and returns one result word.
// - Sits between the evaluator FSM and memory; exactly one command is in flight at a time.

---
 rtl/lisp_mem_pkg.sv | 30 +++
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/mem_client.sv | 166 ++++++++++++++++
 tb/tb_mem_client.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_mem_pkg.sv
// Shared types and constants for the evaluator's memory client: word and
// address widths, command opcodes, client FSM states and cell addressing.
package lisp_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // Command opcodes; encoding 3 is deliberately left out and treated as illegal
  typedef enum logic [1:0] {
    OP_CAR  = 2'd0,
    OP_CDR  = 2'd1,
    OP_CONS = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_WAIT    = 3'd2,
    CONS_ISSUE = 3'd3,
    CONS_WAIT  = 3'd4,
    RESP       = 3'd5
  } state_e;

  // A cell's cdr lives one word above its car; the address space wraps so the
  // top cell's cdr sits at word 0
  function automatic logic [ADDR_W-1:0] cdr_addr(input logic [ADDR_W-1:0] ptr);
    return ptr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter used to give up on a silent memory block.
// The terminal count is reached TIMEOUT enabled cycles after a clear.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles since the last clear, sticking at the terminal value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_client.sv
// Memory client: turns CAR / CDR / CONS commands from the evaluator into
// single read or allocate transactions on the memory block and returns one
// result word (or an error) per command. Only one command is ever in flight.
module mem_client
  import lisp_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              req,
  output logic [ADDR_W-1:0] addr_in,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic              cons_en,
  output logic [DATA_W-1:0] cons_car,
  output logic [DATA_W-1:0] cons_cdr,
  input  logic              cons_done,
  input  logic [DATA_W-1:0] cons_ptr
);

  state_e r_state;
  state_e w_nextState;

  logic              w_ctrClear;
  logic              w_ctrEn;
  logic              w_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_consCar;
  logic [DATA_W-1:0] r_consCdr;
  logic [DATA_W-1:0] r_rspData;
  logic              r_rspErr;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeoutCtr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (w_ctrClear),
    .i_en    (w_ctrEn),
    .o_tc    (w_timeout)
  );

  // State register; reset abandons any outstanding memory transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and counter control; a handshake beats the timeout when both land together
  always_comb begin
    w_nextState = r_state;
    w_ctrClear  = 1'b0;
    w_ctrEn     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CAR, OP_CDR: w_nextState = RD_ISSUE;
            OP_CONS:        w_nextState = CONS_ISSUE;
            default:        w_nextState = RESP;
          endcase
        end
      end
      RD_ISSUE: begin
        w_ctrClear  = 1'b1;
        w_nextState = RD_WAIT;
      end
      RD_WAIT: begin
        w_ctrEn = 1'b1;
        if (data_ready || w_timeout) begin
          w_nextState = RESP;
        end
      end
      CONS_ISSUE: begin
        w_ctrClear  = 1'b1;
        w_nextState = CONS_WAIT;
      end
      CONS_WAIT: begin
        w_ctrEn = 1'b1;
        if (cons_done || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch operands on accept and capture the result word as each wait resolves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_consCar <= '0;
      r_consCdr <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_CAR: r_addr <= cmd_a[ADDR_W-1:0];
              OP_CDR: r_addr <= cdr_addr(cmd_a[ADDR_W-1:0]);
              OP_CONS: begin
                r_consCar <= cmd_a;
                r_consCdr <= cmd_b;
              end
              default: begin
                r_rspData <= '0;
                r_rspErr  <= 1'b1;
              end
            endcase
          end
        end
        RD_WAIT: begin
          if (data_ready) begin
            r_rspData <= data_out;
            r_rspErr  <= 1'b0;
          end else if (w_timeout) begin
            r_rspData <= '0;
            r_rspErr  <= 1'b1;
          end
        end
        CONS_WAIT: begin
          if (cons_done) begin
            r_rspData <= cons_ptr;
            r_rspErr  <= 1'b0;
          end else if (w_timeout) begin
            r_rspData <= '0;
            r_rspErr  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign req       = (r_state == RD_ISSUE);
  assign cons_en   = (r_state == CONS_ISSUE);
  assign rsp_valid = (r_state == RESP);
  assign addr_in   = r_addr;
  assign cons_car  = r_consCar;
  assign cons_cdr  = r_consCdr;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client: a memory-block responder, a scoreboard monitor and a
// stimulus process that predicts each result from a word-level memory model.
module tb_mem_client;

  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        req;
  logic [11:0] addr_in;
  logic        data_ready = 1'b0;
  logic [15:0] data_out = 16'd0;
  logic        cons_en;
  logic [15:0] cons_car;
  logic [15:0] cons_cdr;
  logic        cons_done = 1'b0;
  logic [15:0] cons_ptr = 16'd0;

  int checks = 0;
  int errors = 0;

  rsp_t        expQ[$];
  logic [15:0] memArr [4096];
  int          nextFree = 16;
  int          memDelay = 1;
  bit          memSilent = 1'b0;
  bit          abandon = 1'b0;
  bit          strayReq = 1'b0;
  int          readyMode = 1;
  logic [11:0] expAddr = 12'd0;
  logic [15:0] expCar = 16'd0;
  logic [15:0] expCdr = 16'd0;
  int          reqCount = 0;
  int          consCount = 0;

  mem_client #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .req        (req),
    .addr_in    (addr_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .cons_en    (cons_en),
    .cons_car   (cons_car),
    .cons_cdr   (cons_cdr),
    .cons_done  (cons_done),
    .cons_ptr   (cons_ptr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory block responder: answers each pulse after memDelay cycles unless silent
  initial begin
    for (int i = 0; i < 4096; i++) memArr[i] = 16'hA000 | 16'(i);
    forever begin
      @(posedge clk); #1;
      if (strayReq) begin
        data_ready = 1'b1; data_out = 16'h7777;
        cons_done = 1'b1;  cons_ptr = 16'h0777;
        @(posedge clk); #1;
        data_ready = 1'b0; cons_done = 1'b0;
        strayReq = 1'b0;
      end else if (req) begin
        logic [11:0] a;
        reqCount++;
        checkOutput("req_addr", 32'(addr_in), 32'(expAddr));
        a = addr_in;
        if (!memSilent) begin
          repeat (memDelay) @(posedge clk);
          #1;
          if (!abandon) checkOutput("addr_held", 32'(addr_in), 32'(expAddr));
          data_ready = 1'b1; data_out = memArr[a];
          @(posedge clk); #1;
          data_ready = 1'b0; data_out = 16'd0;
        end
      end else if (cons_en) begin
        logic [15:0] car, cdr;
        consCount++;
        checkOutput("cons_car", 32'(cons_car), 32'(expCar));
        checkOutput("cons_cdr", 32'(cons_cdr), 32'(expCdr));
        car = cons_car; cdr = cons_cdr;
        if (!memSilent) begin
          repeat (memDelay) @(posedge clk);
          #1;
          checkOutput("cons_car_held", 32'(cons_car), 32'(expCar));
          checkOutput("cons_cdr_held", 32'(cons_cdr), 32'(expCdr));
          cons_done = 1'b1; cons_ptr = 16'(nextFree);
          memArr[nextFree % 4096] = car;
          memArr[(nextFree + 1) % 4096] = cdr;
          nextFree = (nextFree + 2) % 4096;
          @(posedge clk); #1;
          cons_done = 1'b0; cons_ptr = 16'd0;
        end
      end
    end
  end

  // Result consumer: random, always-ready or stalled back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       rsp_ready = 1'($urandom_range(0, 1));
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: every accepted result is matched against the oldest prediction
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual data=0x%0h err=%0b required none", rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Predict the result from the memory contents, issue the command, and
  // report cycles from accept until rsp_valid
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                               input bit silent, input int delay, input bit expectRsp,
                               output int lat);
    rsp_t e;
    int   a12;
    int   guard;
    memSilent = silent;
    memDelay  = delay;
    e.data = 16'd0;
    e.err  = 1'b1;
    case (op)
      2'd0, 2'd1: begin
        a12 = (op == 2'd0) ? int'(a) % 4096 : (int'(a) % 4096 + 1) % 4096;
        expAddr = 12'(a12);
        e.data  = silent ? 16'd0 : memArr[a12];
        e.err   = silent;
      end
      2'd2: begin
        expCar = a;
        expCdr = b;
        e.data = silent ? 16'd0 : 16'(nextFree);
        e.err  = silent;
      end
      default: begin
      end
    endcase
    if (expectRsp) expQ.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    if (expectRsp) begin
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 400);
      checkOutput("rsp_arrive", 32'(rsp_valid), 32'd1);
    end
  endtask

  initial begin
    int lat, r0, c0;
    logic [15:0] holdExp;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_cons_en", 32'(cons_en), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_addr_in", 32'(addr_in), 32'd0);
    checkOutput("rst_cons_car", 32'(cons_car), 32'd0);
    checkOutput("rst_cons_cdr", 32'(cons_cdr), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;

    // CONS allocating cell 0x0010, then read both halves back
    applyStimulus(2'd2, 16'hDEAD, 16'hBEEF, 1'b0, 2, 1'b1, lat);
    checkOutput("cons_latency", 32'(lat), 32'd4);
    applyStimulus(2'd0, 16'h0010, 16'h0, 1'b0, 1, 1'b1, lat);
    checkOutput("car_latency", 32'(lat), 32'd3);
    checkOutput("car_model_word", 32'(memArr[16]), 32'hDEAD);
    applyStimulus(2'd1, 16'h0010, 16'h0, 1'b0, 3, 1'b1, lat);
    checkOutput("cdr_latency", 32'(lat), 32'd5);

    // CDR of the top cell wraps to word 0
    applyStimulus(2'd1, 16'h0FFF, 16'h0, 1'b0, 1, 1'b1, lat);

    // Silent memory: timeout error response, one req pulse
    r0 = reqCount;
    applyStimulus(2'd0, 16'h0123, 16'h0, 1'b1, 1, 1'b1, lat);
    checkOutput("timeout_latency", 32'(lat), 32'(TIMEOUT + 3));
    checkOutput("timeout_req_count", 32'(reqCount - r0), 32'd1);

    // Handshake in the terminal-count cycle still delivers data
    applyStimulus(2'd0, 16'h0200, 16'h0, 1'b0, TIMEOUT + 1, 1'b1, lat);
    checkOutput("late_hs_latency", 32'(lat), 32'(TIMEOUT + 3));

    // Illegal op: error with no memory traffic
    r0 = reqCount; c0 = consCount;
    applyStimulus(2'd3, 16'h0010, 16'h0, 1'b0, 1, 1'b1, lat);
    checkOutput("illegal_latency", 32'(lat), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("illegal_no_req", 32'(reqCount - r0), 32'd0);
    checkOutput("illegal_no_cons", 32'(consCount - c0), 32'd0);

    // Stray handshakes in IDLE produce nothing
    strayReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("stray_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Back-pressure: response held while rsp_ready stays low
    readyMode = 2;
    holdExp = memArr[12'h345];
    applyStimulus(2'd0, 16'h0345, 16'h0, 1'b0, 2, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_data", 32'(rsp_data), 32'(holdExp));
      checkOutput("hold_err", 32'(rsp_err), 32'd0);
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    readyMode = 1;

    // Reset during RD_WAIT; the late data_ready must be ignored
    applyStimulus(2'd0, 16'h0020, 16'h0, 1'b0, 6, 1'b0, lat);
    repeat (3) @(posedge clk);
    #2;
    abandon = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(req), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midrst_addr_in", 32'(addr_in), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    abandon = 1'b0;
    applyStimulus(2'd1, 16'h0020, 16'h0, 1'b0, 1, 1'b1, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd3);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [15:0] a, b;
      bit          silent;
      int          dly, sel, expLat;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      a   = ($urandom_range(0, 3) == 0) ? 16'h0FFF : 16'($urandom);
      b   = 16'($urandom);
      silent = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(1, 4);
      readyMode = ($urandom_range(0, 1) == 0) ? 0 : 1;
      applyStimulus(op, a, b, silent, dly, 1'b1, lat);
      expLat = (op == 2'd3) ? 1 : silent ? TIMEOUT + 3 : dly + 2;
      checkOutput("rand_latency", 32'(lat), 32'(expLat));
    end

    readyMode = 1;
    for (int i = 0; i < 100 && expQ.size() > 0; i++) @(negedge clk);
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
